// File: rtl/sram_2p_init.sv
// sram_2p_init: simple-dual-port synchronous SRAM with byte enables, 1/2-cycle read latency
// and a clear sequencer that zeroes every location after reset or on CLR.
`default_nettype none

module sram_2p_init #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int OUT_REG  = 0,
  parameter int WR_FIRST = 0
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                CLR,
  input  logic                WREN,
  input  logic [ADDR_W-1:0]   WADDR,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WBE,
  input  logic                RDEN,
  input  logic [ADDR_W-1:0]   RADDR,
  output logic [DATA_W-1:0]   RDATA,
  output logic                RVALID,
  output logic                BUSY
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   cnt, cnt_nxt;
  logic                init_wr, wr_go, rd_go;
  logic [DATA_W-1:0]   rd_word;
  logic [DATA_W-1:0]   mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    init_wr   = 1'b0;
    wr_go     = 1'b0;
    rd_go     = 1'b0;
    case (state)
      INIT: begin
        init_wr = 1'b1;
        cnt_nxt = cnt + 1'b1;
        if (&cnt) state_nxt = READY;
      end
      READY: begin
        if (CLR) begin
          state_nxt = INIT;
          cnt_nxt   = '0;
        end else begin
          wr_go = WREN;
          rd_go = RDEN;
        end
      end
      default: state_nxt = INIT;
    endcase
  end

  assign BUSY = (state == INIT);

  // Memory contents are deliberately untouched while reset is held.
  always_ff @(posedge CLK) begin
    if (RST_N) begin
      if (init_wr) begin
        mem[cnt] <= '0;
      end else if (wr_go) begin
        for (int i = 0; i < NB; i++) begin
          if (WBE[i]) mem[WADDR][8*i +: 8] <= WDATA[8*i +: 8];
        end
      end
    end
  end

  // The array read sees pre-write contents; write-first merges the enabled bytes in.
  always_comb begin
    rd_word = mem[RADDR];
    if ((WR_FIRST != 0) && wr_go && (WADDR == RADDR)) begin
      for (int i = 0; i < NB; i++) begin
        if (WBE[i]) rd_word[8*i +: 8] = WDATA[8*i +: 8];
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_W-1:0] pipe_data;
      logic              pipe_vld;

      always_ff @(posedge CLK) begin
        if (!RST_N) begin
          pipe_data <= '0;
          pipe_vld  <= 1'b0;
          RDATA     <= '0;
          RVALID    <= 1'b0;
        end else begin
          pipe_vld <= rd_go;
          if (rd_go) pipe_data <= rd_word;
          RVALID <= pipe_vld;
          if (pipe_vld) RDATA <= pipe_data;
        end
      end
    end else begin : g_no_out_reg
      always_ff @(posedge CLK) begin
        if (!RST_N) begin
          RDATA  <= '0;
          RVALID <= 1'b0;
        end else begin
          RVALID <= rd_go;
          if (rd_go) RDATA <= rd_word;
        end
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_sram_2p_init.sv
// tb_sram_2p_init: directed checks of two sram_2p_init instances sharing stimulus
// (A: 1-cycle read-first, B: 2-cycle write-first), both 16-bit wide.
`default_nettype none

module tb_sram_2p_init;

  logic        clk = 1'b0;
  logic        rst_n, clr, wren, rden;
  logic [3:0]  waddr, raddr;
  logic [15:0] wdata;
  logic [1:0]  wbe;
  logic [15:0] rdata_a, rdata_b;
  logic        rvalid_a, rvalid_b, busy_a, busy_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sram_2p_init #(.DATA_W(16), .ADDR_W(4), .OUT_REG(0), .WR_FIRST(0)) dut_a (
    .CLK(clk), .RST_N(rst_n), .CLR(clr), .WREN(wren), .WADDR(waddr), .WDATA(wdata),
    .WBE(wbe), .RDEN(rden), .RADDR(raddr), .RDATA(rdata_a), .RVALID(rvalid_a), .BUSY(busy_a)
  );

  sram_2p_init #(.DATA_W(16), .ADDR_W(4), .OUT_REG(1), .WR_FIRST(1)) dut_b (
    .CLK(clk), .RST_N(rst_n), .CLR(clr), .WREN(wren), .WADDR(waddr), .WDATA(wdata),
    .WBE(wbe), .RDEN(rden), .RADDR(raddr), .RDATA(rdata_b), .RVALID(rvalid_b), .BUSY(busy_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    clr  = 1'b0;
    wren = 1'b0;
    rden = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
    wren = 1'b1; waddr = a; wdata = d; wbe = be;
    @(posedge clk); #1;
    wren = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [3:0] a,
                         input logic [15:0] ea, input logic [15:0] eb);
    rden = 1'b1; raddr = a;
    @(posedge clk); #1;
    rden = 1'b0;
    check_eq({tag, "_rvalid_a"}, rvalid_a, 1'b1);
    check_eq({tag, "_rdata_a"}, rdata_a, ea);
    check_eq({tag, "_rvalid_b_early"}, rvalid_b, 1'b0);
    @(posedge clk); #1;
    check_eq({tag, "_rvalid_b"}, rvalid_b, 1'b1);
    check_eq({tag, "_rdata_b"}, rdata_b, eb);
    check_eq({tag, "_rvalid_a_drop"}, rvalid_a, 1'b0);
  endtask

  task automatic fill(input logic [15:0] d);
    for (int i = 0; i < 16; i++) do_write(i[3:0], d, 2'b11);
  endtask

  task automatic read_all_zero(input string tag);
    for (int i = 0; i < 16; i++) do_read(tag, i[3:0], 16'h0000, 16'h0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; idle(); waddr = '0; raddr = '0; wdata = '0; wbe = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy_a", busy_a, 1'b1);
    check_eq("rst_busy_b", busy_b, 1'b1);
    check_eq("rst_rvalid_a", rvalid_a, 1'b0);
    check_eq("rst_rvalid_b", rvalid_b, 1'b0);
    check_eq("rst_rdata_a", rdata_a, 16'h0);
    check_eq("rst_rdata_b", rdata_b, 16'h0);

    // Release reset with commands asserted; they must all be ignored during INIT.
    rst_n = 1'b1; clr = 1'b1; wren = 1'b1; waddr = 4'd0; wdata = 16'hFFFF; wbe = 2'b11;
    rden = 1'b1; raddr = 4'd0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      check_eq("init_busy_a", busy_a, (k < 15));
      check_eq("init_busy_b", busy_b, (k < 15));
      check_eq("init_rvalid_a", rvalid_a, 1'b0);
      check_eq("init_rvalid_b", rvalid_b, 1'b0);
    end
    idle();
    read_all_zero("init_rd");

    // Byte enables
    do_write(4'd3, 16'hA5A5, 2'b11);
    do_write(4'd3, 16'h3C00, 2'b10);
    do_read("be_merge", 4'd3, 16'h3CA5, 16'h3CA5);
    do_write(4'd3, 16'hFFFF, 2'b00);
    do_read("be_none", 4'd3, 16'h3CA5, 16'h3CA5);

    // Collision: full-word then partial-byte
    do_write(4'd7, 16'h0011, 2'b11);
    wren = 1'b1; waddr = 4'd7; wdata = 16'h0022; wbe = 2'b11; rden = 1'b1; raddr = 4'd7;
    @(posedge clk); #1;
    idle();
    check_eq("coll_rdata_a", rdata_a, 16'h0011);
    @(posedge clk); #1;
    check_eq("coll_rdata_b", rdata_b, 16'h0022);
    do_read("coll_after", 4'd7, 16'h0022, 16'h0022);
    wren = 1'b1; waddr = 4'd7; wdata = 16'h5500; wbe = 2'b10; rden = 1'b1; raddr = 4'd7;
    @(posedge clk); #1;
    idle();
    check_eq("coll_part_a", rdata_a, 16'h0022);
    @(posedge clk); #1;
    check_eq("coll_part_b", rdata_b, 16'h5522);
    do_read("coll_part_after", 4'd7, 16'h5522, 16'h5522);

    // Latency: back-to-back reads of 0..3
    for (int i = 0; i < 4; i++) do_write(i[3:0], 16'h0010 + 16'(i), 2'b11);
    for (int j = 0; j < 7; j++) begin
      rden = (j < 4); raddr = j[3:0];
      @(posedge clk); #1;
      check_eq("lat_rvalid_a", rvalid_a, (j < 4));
      check_eq("lat_rvalid_b", rvalid_b, (j >= 1 && j <= 4));
      if (j < 4) check_eq("lat_rdata_a", rdata_a, 16'h0010 + 16'(j));
      if (j >= 1 && j <= 4) check_eq("lat_rdata_b", rdata_b, 16'h000F + 16'(j));
    end
    rden = 1'b0;
    check_eq("lat_hold_a", rdata_a, 16'h0013);
    check_eq("lat_hold_b", rdata_b, 16'h0013);

    // CLR with a read in flight (B only) and same-cycle write/read dropped
    fill(16'hFFFF);
    rden = 1'b1; raddr = 4'd2;
    @(posedge clk); #1;
    check_eq("clr_pre_rvalid_a", rvalid_a, 1'b1);
    check_eq("clr_pre_rdata_a", rdata_a, 16'hFFFF);
    clr = 1'b1; wren = 1'b1; waddr = 4'd5; wdata = 16'h1234; wbe = 2'b11; rden = 1'b1; raddr = 4'd4;
    @(posedge clk); #1;
    idle();
    check_eq("clr_busy", busy_a, 1'b1);
    check_eq("clr_rvalid_a", rvalid_a, 1'b0);
    check_eq("clr_inflight_rvalid_b", rvalid_b, 1'b1);
    check_eq("clr_inflight_rdata_b", rdata_b, 16'hFFFF);
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      check_eq("clr_busy_a", busy_a, (k < 16));
      check_eq("clr_busy_b", busy_b, (k < 16));
      check_eq("clr_rvalid_a_q", rvalid_a, 1'b0);
      check_eq("clr_rvalid_b_q", rvalid_b, 1'b0);
    end
    check_eq("clr_hold_a", rdata_a, 16'hFFFF);
    read_all_zero("clr_rd");

    // Reset at cycle 5 of a clear sequence
    fill(16'hFFFF);
    do_read("mid_pre", 4'd9, 16'hFFFF, 16'hFFFF);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_eq("mid_busy_c5", busy_a, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("mid_rst_rdata_a", rdata_a, 16'h0);
    check_eq("mid_rst_rdata_b", rdata_b, 16'h0);
    check_eq("mid_rst_busy", busy_a, 1'b1);
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      check_eq("mid_busy_a", busy_a, (k < 15));
      check_eq("mid_busy_b", busy_b, (k < 15));
    end
    read_all_zero("mid_rd");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
